gc_table_packer: RTL and testbench

GC_TABLE_PACKER -- requirements
Module: gc_table_packer

---
 rtl/gc_table_packer.sv | 206 ++++++++++++++++++++
 tb/tb_gc_table_packer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_table_packer.sv
// -----------------------------------------------------------------------------
// gc_table_packer
//
// Buffers half-gate garbled-table entries coming from a garbling engine and
// serialises each one onto a W-bit output stream. Every gate produces
// N = 2K/W table words: the words of t0 from the least-significant end
// upward, then the words of t1 likewise.
//
// Optional feature (macro GC_PACKER_HDR_EN):
//   When defined, each gate is preceded by a header word {(W-S) zeros, gid},
//   so a gate occupies N+1 words. out_last still marks the final t1 word.
//   When undefined, gid is ignored and not stored.
//
// Parameters:
//   K     - label / table-row width in bits (2K must be a multiple of W)
//   S     - gate-id width in bits (S <= W)
//   W     - output word width in bits
//   DEPTH - number of buffered gate entries (power of 2, >= 2)
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst_n       - asynchronous active-low reset
//   in_valid_i  - an engine result is presented
//   in_ready_o  - the packer accepts an entry this cycle
//   gid_i       - gate id of the presented entry
//   t0_i, t1_i  - half-gate garbled-table rows
//   out_valid_o - out_data_o holds a valid word
//   out_ready_i - downstream consumes the current word
//   out_data_o  - serialised table word (0 when out_valid_o is low)
//   out_last_o  - current word is the final word of its gate
//   level_o     - number of buffered entries
// -----------------------------------------------------------------------------
module gc_table_packer #(
    parameter int unsigned K     = 128,
    parameter int unsigned S     = 20,
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [S-1:0]                 gid_i,
    input  logic [K-1:0]                 t0_i,
    input  logic [K-1:0]                 t1_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [W-1:0]                 out_data_o,
    output logic                         out_last_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    // Table words per gate.
    localparam int unsigned N = (2 * K) / W;

`ifdef GC_PACKER_HDR_EN
    localparam int unsigned HdrW = 1;
    localparam int unsigned EW   = S + 2 * K;
`else
    localparam int unsigned HdrW = 0;
    localparam int unsigned EW   = 2 * K;
`endif

    // Words emitted per gate, including the optional header.
    localparam int unsigned NW = N + HdrW;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LastWord = CW'(NW - 1);
    localparam logic [LW-1:0] FullLvl  = LW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [CW-1:0] wcnt_q,   wcnt_d;

    // Held low through reset and for the first edge after it so that
    // in_ready_o reads 0 while rst_n is asserted.
    logic          rdy_en_q;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic          out_valid;
    logic          in_ready;
    logic          word_last;
    logic          push;
    logic          beat;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;
    logic [2*K-1:0] head_tbl;
    logic [W-1:0]  word;

    // Full/empty come from the registered level only, so neither ready nor
    // valid has a combinational path from the opposite handshake input.
    always_comb begin
        out_valid = (level_q != '0);
        in_ready  = rdy_en_q && (level_q != FullLvl);
        word_last = (wcnt_q == LastWord);
        push      = in_valid_i && in_ready;
        beat      = out_valid && out_ready_i;
        pop       = beat && word_last;
    end

`ifdef GC_PACKER_HDR_EN
    assign wr_entry = {gid_i, t1_i, t0_i};
`else
    logic unused_gid;
    assign unused_gid = ^gid_i;
    assign wr_entry   = {t1_i, t0_i};
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wcnt_d   = wcnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (beat) begin
            wcnt_d = word_last ? '0 : wcnt_q + CW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wcnt_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wcnt_q   <= wcnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Entry storage carries no reset; stale contents are never observable
    // because out_data_o is forced to 0 whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Output word selection
    // -------------------------------------------------------------------------
    assign head     = mem_q[rd_ptr_q];
    assign head_tbl = head[2*K-1:0];

    always_comb begin
        word = '0;
        // Table word i sits at stream position i + HdrW.
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(wcnt_q) == i + HdrW) begin
                word = head_tbl[i*W +: W];
            end
        end
`ifdef GC_PACKER_HDR_EN
        if (wcnt_q == '0) begin
            word = W'(head[EW-1 -: S]);
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign out_data_o  = out_valid ? word : '0;
    assign out_last_o  = out_valid && word_last;
    assign level_o     = level_q;

endmodule

// File: tb/tb_gc_table_packer.sv
// -----------------------------------------------------------------------------
// tb_gc_table_packer
//
// Directed self-checking bench for gc_table_packer at K=128, S=20, W=64,
// DEPTH=4. Builds with or without GC_PACKER_HDR_EN; expected streams account
// for the header word when the macro is defined.
// -----------------------------------------------------------------------------
module tb_gc_table_packer;

    localparam int K     = 128;
    localparam int S     = 20;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

`ifdef GC_PACKER_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    localparam int NW = (2 * K) / W + HDR;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [S-1:0]    gid;
    logic [K-1:0]    t0;
    logic [K-1:0]    t1;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [LW-1:0]   level;

    int total;
    int bad;

    gc_table_packer #(
        .K     (K),
        .S     (S),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .gid_i       (gid),
        .t0_i        (t0),
        .t1_i        (t1),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference word idx of a gate: optional header, t0 low-to-high, t1 likewise.
    function automatic logic [W-1:0] word_of(input logic [S-1:0] g, input logic [K-1:0] a,
                                             input logic [K-1:0] b, input int idx);
        logic [2*K-1:0] tbl;
        tbl = {b, a};
        if (HDR == 1 && idx == 0) return W'(g);
        return tbl[(idx-HDR)*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gid       = '0;
        t0        = '0;
        t1        = '0;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (out_data !== '0) begin
            bad++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        total++;
        if (out_last !== 1'b0) begin
            bad++; $display("FAIL reset_out_last: got %b want 0", out_last);
        end
        total++;
        if (level !== '0) begin
            bad++; $display("FAIL reset_level: got %0d want 0", level);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_before_edge: got %b want 0", in_ready);
        end
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_after_edge: got %b want 1", in_ready);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_gate();
        logic [W-1:0] exp_w [$];
        exp_w = '{64'h71A6B17B1979977D, 64'h1C64A9FAFFB69054,
                  64'h0B64A1973415FC1B, 64'hC17835695FF945D3};
`ifdef GC_PACKER_HDR_EN
        exp_w.push_front(64'h0000000000000ABC);
`endif
        gid       = 20'h00ABC;
        t0        = 128'h1C64A9FAFFB6905471A6B17B1979977D;
        t1        = 128'hC17835695FF945D30B64A1973415FC1B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        // No same-cycle bypass.
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_no_bypass: got out_valid=%b want 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < NW; w++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_w[w]) begin
                bad++;
                $display("FAIL single_word%0d: got v=%b %h want v=1 %h",
                         w, out_valid, out_data, exp_w[w]);
            end
            total++;
            if (out_last !== (w == NW - 1)) begin
                bad++;
                $display("FAIL single_last%0d: got %b want %b", w, out_last, (w == NW - 1));
            end
            tick();
        end
        total++;
        if (level !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drained: got level=%0d v=%b want level=0 v=0", level, out_valid);
        end
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        logic [K-1:0] ta [5];
        logic [K-1:0] tb [5];
        logic [W-1:0] w0;
        int pushed;
        pushed = 0;
        for (int i = 0; i < 5; i++) begin
            ta[i] = {32'hA000_0000 + 32'(i), 32'h0123_4567, 32'h89AB_CDEF ^ 32'(i), 32'h1111_0000};
            tb[i] = {32'hB000_0000 + 32'(i), 32'hFEDC_BA98, 32'h7654_3210, 32'h2222_0000 + 32'(i)};
        end
        w0 = word_of(20'(0), ta[0], tb[0], 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gid      = 20'(i);
            t0       = ta[i];
            t1       = tb[i];
            in_valid = 1'b1;
            if (in_ready === 1'b1) pushed++;
            if (i > 0) begin
                total++;
                if (out_data !== w0) begin
                    bad++; $display("FAIL bp_hold%0d: got %h want %h", i, out_data, w0);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (pushed != 4) begin
            bad++; $display("FAIL bp_accepted: got %0d want 4", pushed);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        total++;
        if (level !== LW'(4)) begin
            bad++; $display("FAIL bp_level: got %0d want 4", level);
        end
        total++;
        if (out_data !== w0 || out_last !== (NW == 1)) begin
            bad++; $display("FAIL bp_head: got %h last=%b want %h", out_data, out_last, w0);
        end
        out_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < NW; w++) begin
                total++;
                if (out_data !== word_of(20'(g), ta[g], tb[g], w) || out_last !== (w == NW - 1)) begin
                    bad++;
                    $display("FAIL bp_drain g%0d w%0d: got %h last=%b want %h last=%b", g, w,
                             out_data, out_last, word_of(20'(g), ta[g], tb[g], w), (w == NW - 1));
                end
                tick();
            end
        end
        total++;
        if (level !== '0) begin
            bad++; $display("FAIL bp_final_level: got %0d want 0", level);
        end
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_push_pop();
        logic [S-1:0] ga [3];
        logic [K-1:0] ta [3];
        logic [K-1:0] tb [3];
        for (int i = 0; i < 3; i++) begin
            ga[i] = 20'h11 * 20'(i + 1);
            ta[i] = {4{32'hC0DE_0000 + 32'(i)}};
            tb[i] = {4{32'hF00D_0000 + 32'(i * 3)}};
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            gid = ga[i]; t0 = ta[i]; t1 = tb[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (level !== LW'(2)) begin
            bad++; $display("FAIL pp_level_pre: got %0d want 2", level);
        end
        out_ready = 1'b1;
        for (int w = 0; w < NW; w++) begin
            total++;
            if (out_data !== word_of(ga[0], ta[0], tb[0], w)) begin
                bad++;
                $display("FAIL pp_a_w%0d: got %h want %h", w, out_data, word_of(ga[0], ta[0], tb[0], w));
            end
            if (w == NW - 1) begin
                gid = ga[2]; t0 = ta[2]; t1 = tb[2]; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        total++;
        if (level !== LW'(2)) begin
            bad++; $display("FAIL pp_level_same: got %0d want 2", level);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== word_of(ga[1], ta[1], tb[1], 0)) begin
            bad++;
            $display("FAIL pp_no_bubble: got v=%b %h want v=1 %h", out_valid, out_data,
                     word_of(ga[1], ta[1], tb[1], 0));
        end
        for (int g = 1; g < 3; g++) begin
            for (int w = 0; w < NW; w++) begin
                total++;
                if (out_data !== word_of(ga[g], ta[g], tb[g], w) || out_last !== (w == NW - 1)) begin
                    bad++;
                    $display("FAIL pp_drain g%0d w%0d: got %h last=%b want %h", g, w, out_data,
                             out_last, word_of(ga[g], ta[g], tb[g], w));
                end
                tick();
            end
        end
        total++;
        if (level !== '0) begin
            bad++; $display("FAIL pp_final_level: got %0d want 0", level);
        end
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [K-1:0] td0, td1, te0, te1;
        td0 = {32'h1, 32'h2, 32'h3, 32'h4};
        td1 = {32'h5, 32'h6, 32'h7, 32'h8};
        te0 = {32'h9ABC_DEF0, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0};
        te1 = {32'h5A5A_A5A5, 32'h3C3C_C3C3, 32'h6969_9696, 32'hFFFF_0001};
        gid = 20'h0D; t0 = td0; t1 = td1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            total++;
            if (out_data !== word_of(20'h0D, td0, td1, w)) begin
                bad++;
                $display("FAIL rm_pre_w%0d: got %h want %h", w, out_data, word_of(20'h0D, td0, td1, w));
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== '0 || out_data !== '0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rm_async: got v=%b lvl=%0d d=%h rdy=%b want 0 0 0 0",
                     out_valid, level, out_data, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        gid = 20'h0E; t0 = te0; t1 = te1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < NW; w++) begin
            total++;
            if (out_data !== word_of(20'h0E, te0, te1, w) || out_last !== (w == NW - 1)) begin
                bad++;
                $display("FAIL rm_post_w%0d: got %h last=%b want %h", w, out_data, out_last,
                         word_of(20'h0E, te0, te1, w));
            end
            tick();
        end
        total++;
        if (level !== '0) begin
            bad++; $display("FAIL rm_final_level: got %0d want 0", level);
        end
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wrap();
        logic [W-1:0] exp_w [$];
        logic         exp_l [$];
        logic [K-1:0] a, b;
        int sent;
        int mlevel;
        int cyc;
        logic mpush, mbeat;
        sent   = 0;
        mlevel = 0;
        cyc    = 0;
        while (cyc < 2000 && (sent < 10 || exp_w.size() > 0)) begin
            total++;
            if (out_valid !== (mlevel != 0) || level !== LW'(mlevel) ||
                in_ready !== (mlevel != DEPTH)) begin
                bad++;
                $display("FAIL wrap_state c%0d: got v=%b lvl=%0d rdy=%b want lvl=%0d",
                         cyc, out_valid, level, in_ready, mlevel);
            end
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 10);
            gid = 20'(sent + 100); t0 = a; t1 = b;
            mpush = in_valid && (mlevel != DEPTH);
            mbeat = (mlevel != 0) && out_ready;
            if (mbeat) begin
                total++;
                if (out_data !== exp_w[0] || out_last !== exp_l[0]) begin
                    bad++;
                    $display("FAIL wrap_word c%0d: got %h last=%b want %h last=%b",
                             cyc, out_data, out_last, exp_w[0], exp_l[0]);
                end
                if (exp_l[0]) mlevel--;
                void'(exp_w.pop_front());
                void'(exp_l.pop_front());
            end
            if (mpush) begin
                for (int w = 0; w < NW; w++) begin
                    exp_w.push_back(word_of(20'(sent + 100), a, b, w));
                    exp_l.push_back(w == NW - 1);
                end
                mlevel++;
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (sent != 10 || exp_w.size() != 0) begin
            bad++;
            $display("FAIL wrap_timeout: got sent=%0d pending=%0d want 10 0", sent, exp_w.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_gate();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
